// File: rtl/fib_index_sequencer_pkg.sv
// Shared types and helpers for the Fibonacci index sequencer.
package fib_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int F_INIT = 1;

  // Each step advances the pair by two terms, so n needs n>>1 steps.
  function automatic int unsigned step_count(input int unsigned n);
    return n >> 1;
  endfunction

endpackage

// File: rtl/fib_index_sequencer_if.sv
// Request/response handshake bundle between requester/consumer and sequencer.
interface fib_index_sequencer_if #(parameter int W = 16, parameter int IW = 6);
  logic          req_valid;
  logic          req_ready;
  logic [IW-1:0] req_index;
  logic          resp_valid;
  logic          resp_ready;
  logic [W-1:0]  resp_data;
  logic          resp_ovf;
  logic          busy;

  modport master (
    output req_valid, req_index, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_ovf, busy
  );

  modport slave (
    input  req_valid, req_index, resp_ready,
    output req_ready, resp_valid, resp_data, resp_ovf, busy
  );
endinterface

// File: rtl/fib_index_sequencer_pair_core.sv
// Double-rate Fibonacci register pair: a,b hold F(k),F(k+1); one step yields F(k+2),F(k+3).
module fib_pair_core
  import fib_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic         ovf_a,
  output logic         ovf_b
);

  logic [W:0]   sum_a;
  logic [W+1:0] sum_b;

  assign sum_a = {1'b0, a} + {1'b0, b};
  assign sum_b = {2'b00, a} + {2'b00, b} + {2'b00, b};

  // Overflow is sticky and inherited from both terms, since later terms are larger.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a     <= W'(F_INIT);
      b     <= W'(F_INIT);
      ovf_a <= 1'b0;
      ovf_b <= 1'b0;
    end else if (load) begin
      a     <= W'(F_INIT);
      b     <= W'(F_INIT);
      ovf_a <= 1'b0;
      ovf_b <= 1'b0;
    end else if (step) begin
      a     <= sum_a[W-1:0];
      b     <= sum_b[W-1:0];
      ovf_a <= ovf_a | ovf_b | sum_a[W];
      ovf_b <= ovf_a | ovf_b | (|sum_b[W+1:W]);
    end
  end

endmodule

// File: rtl/fib_index_sequencer.sv
// Returns F(n) (F(0)=F(1)=1) modulo 2^W with an overflow flag over valid/ready handshakes.
module fib_index_sequencer
  import fib_pkg::*;
#(
  parameter int W  = 16,
  parameter int IW = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  fib_index_sequencer_if.slave  bus
);

  state_t        state, nxt;
  logic [IW-1:0] cnt;
  logic          sel;
  logic          load, step;
  logic [W-1:0]  a, b;
  logic          ovf_a, ovf_b;

  fib_pair_core #(.W(W)) u_core (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .step  (step),
    .a     (a),
    .b     (b),
    .ovf_a (ovf_a),
    .ovf_b (ovf_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sel   <= 1'b0;
    end else begin
      state <= nxt;
      if (load) begin
        cnt <= IW'(step_count(32'(bus.req_index)));
        sel <= bus.req_index[0];
      end else if (step) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  always_comb begin
    nxt  = state;
    load = 1'b0;
    step = 1'b0;
    case (state)
      IDLE: if (bus.req_valid) begin
        load = 1'b1;
        nxt  = RUN;
      end
      RUN: if (cnt != '0) step = 1'b1;
           else           nxt  = DONE;
      DONE: if (bus.resp_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs depend on registers only; the odd term comes from b.
  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == DONE);
  assign bus.busy       = (state != IDLE);
  assign bus.resp_data  = (state == DONE) ? (sel ? b : a) : '0;
  assign bus.resp_ovf   = (state == DONE) ? (sel ? ovf_b : ovf_a) : 1'b0;

endmodule

// File: tb/tb_fib_index_sequencer.sv
// Scoreboard bench: W=16 and W=8 sequencers driven in lockstep, checked against a plain Fibonacci model.
module tb_fib_index_sequencer;

  typedef struct {
    int unsigned n;
    int          acc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [5:0] req_index = '0;
  logic       resp_ready = 1'b0;
  int         ready_mode = 1;
  int         cyc = 0;
  int         errs = 0;
  int         checks = 0;

  exp_t q0[$];
  exp_t q1[$];
  logic        seen [2];
  logic        prev_hs [2];
  logic [63:0] hd [2];
  logic        ho [2];

  fib_index_sequencer_if #(.W(16), .IW(6)) bus16 ();
  fib_index_sequencer_if #(.W(8),  .IW(6)) bus8 ();

  assign bus16.req_valid  = req_valid;
  assign bus16.req_index  = req_index;
  assign bus16.resp_ready = resp_ready;
  assign bus8.req_valid   = req_valid;
  assign bus8.req_index   = req_index;
  assign bus8.resp_ready  = resp_ready;

  fib_index_sequencer #(.W(16), .IW(6)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  fib_index_sequencer #(.W(8),  .IW(6)) dut8  (.clk(clk), .rst(rst), .bus(bus8));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Consumer: ready held low, held high, or random per cycle.
  always @(posedge clk) begin
    #1;
    if (ready_mode == 2) resp_ready = 1'($urandom_range(0, 1));
    else                 resp_ready = (ready_mode != 0);
  end

  function automatic logic [63:0] fib(input int unsigned n);
    logic [63:0] x, y, t;
    x = 64'd1;
    y = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      t = x + y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic mon(input int i, input int w, input logic [63:0] d, input logic o,
                     input logic rv, input logic rdy, input logic bsy);
    exp_t        e;
    int          qs;
    logic [63:0] f;
    string       tag;
    tag = (w == 16) ? "w16" : "w8";
    if (prev_hs[i]) begin
      chk({tag, "_idle_after_resp"}, {62'd0, rv, rdy}, 64'd1);
      prev_hs[i] = 1'b0;
    end
    if (rv) begin
      if (!seen[i]) begin
        qs = (i == 0) ? q0.size() : q1.size();
        chk({tag, "_resp_has_request"}, 64'(qs > 0), 64'd1);
        if (qs > 0) begin
          e = (i == 0) ? q0.pop_front() : q1.pop_front();
          f = fib(e.n);
          chk({tag, "_data"}, d, f & ((64'd1 << w) - 64'd1));
          chk({tag, "_ovf"}, 64'(o), 64'(f >= (64'd1 << w)));
          chk({tag, "_latency"}, 64'(cyc - e.acc), 64'((e.n >> 1) + 1));
        end
        seen[i] = 1'b1;
        hd[i]   = d;
        ho[i]   = o;
      end else begin
        chk({tag, "_hold_data"}, d, hd[i]);
        chk({tag, "_hold_ovf"}, 64'(o), 64'(ho[i]));
      end
      chk({tag, "_ready_busy_in_done"}, {62'd0, rdy, bsy}, 64'd1);
      if (resp_ready) begin
        seen[i]    = 1'b0;
        prev_hs[i] = 1'b1;
      end
    end else begin
      chk({tag, "_idle_outputs_zero"}, {d[62:0], o}, 64'd0);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      seen    = '{1'b0, 1'b0};
      prev_hs = '{1'b0, 1'b0};
    end else begin
      mon(0, 16, 64'(bus16.resp_data), bus16.resp_ovf, bus16.resp_valid, bus16.req_ready, bus16.busy);
      mon(1, 8,  64'(bus8.resp_data),  bus8.resp_ovf,  bus8.resp_valid,  bus8.req_ready,  bus8.busy);
    end
  end

  task automatic issue(input int unsigned n);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_index = 6'(n);
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (bus16.req_ready) begin
        e.n   = n;
        e.acc = cyc + 1;
        q0.push_back(e);
        q1.push_back(e);
        ok = 1'b1;
      end
    end
    if (!ok) chk("issue_accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      done = (q0.size() == 0) && (q1.size() == 0) && !bus16.resp_valid && !bus8.resp_valid;
    end
    if (!done) chk("drain_timeout", 64'd0, 64'd1);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_w16"}, {bus16.req_ready, bus16.resp_valid, bus16.busy, bus16.resp_ovf, 16'(bus16.resp_data)}, {4'b1000, 16'd0});
    chk({nm, "_w8"},  {bus8.req_ready,  bus8.resp_valid,  bus8.busy,  bus8.resp_ovf,  8'(bus8.resp_data)},  {4'b1000, 8'd0});
  endtask

  initial begin
    bit got;
    int unsigned directed [6] = '{0, 10, 23, 24, 12, 13};
    #2;
    chk_reset_outputs("reset_state");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    ready_mode = 1;
    foreach (directed[k]) begin
      issue(directed[k]);
      drain();
    end

    // Back-pressure with a second request held during DONE.
    ready_mode = 0;
    issue(5);
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      got = bus16.resp_valid;
    end
    chk("bp_resp_seen", 64'(got), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_index = 6'd9;
    repeat (5) @(negedge clk);
    chk("bp_still_done", {62'd0, bus16.resp_valid, bus16.req_ready}, 64'd2);
    @(posedge clk); #1;
    req_valid  = 1'b0;
    ready_mode = 1;
    drain();

    // Reset mid-RUN drops the transaction.
    issue(20);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk_reset_outputs("reset_mid_run");
    q0.delete();
    q1.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(negedge clk);

    ready_mode = 2;
    for (int r = 0; r < 40; r++) begin
      issue($urandom_range(0, 63));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
